// File: rtl/sram_fe_pkg.sv
// rtl/sram_fe_pkg.sv - shared widths, types and helpers for the SRAM request front-end
package sram_fe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t wdata;
    } req_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_fe_rsp_fifo.sv
// rtl/sram_fe_rsp_fifo.sv - circular response FIFO; pointers wrap modulo DEPTH (any depth >= 1)
module sram_fe_rsp_fifo
    import sram_fe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_pop,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop & o_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_frontend.sv
// rtl/sram_req_frontend.sv - request stream to single-port SRAM strobes with credit-limited read responses
// Optional macro SRAM_FE_STATS_EN adds 32-bit read/write fire counters (stat_rd_cnt, stat_wr_cnt).
module sram_req_frontend
    import sram_fe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_FE_STATS_EN
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt,
`endif
    output logic              ram_ce_in,
    output logic              ram_we_in,
    output logic [ADDR_W-1:0] ram_addr_in,
    output logic [DATA_W-1:0] ram_wd_in,
    input  logic [DATA_W-1:0] ram_rd_out
);

    localparam int CNT_W = cnt_width(RSP_DEPTH);

    generate
        if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
            $error("sram_req_frontend: ADDR_W must equal clog2(DEPTH)");
        end
    endgenerate

    logic             w_fire;
    logic             w_rd_fire;
    logic             w_wr_fire;
    logic             r_rd_pend;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_credits_used;

    // A credit is held from the read fire until its response is popped,
    // so the FIFO can never be pushed while full.
    assign w_credits_used = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_rd_pend};
    assign req_ready      = ~rst & (w_credits_used < (CNT_W + 1)'(RSP_DEPTH));

    assign w_fire    = req_valid & req_ready;
    assign w_rd_fire = w_fire & ~req_we;
    assign w_wr_fire = w_fire & req_we;

    // Gate everything with fire so idle or X request fields never reach the macro.
    assign ram_ce_in   = w_fire;
    assign ram_we_in   = w_wr_fire;
    assign ram_addr_in = w_fire ? req_addr : '0;
    assign ram_wd_in   = w_wr_fire ? req_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_fire;
        end
    end

    sram_fe_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_pend),
        .i_data  (ram_rd_out),
        .i_pop   (rsp_ready),
        .o_valid (rsp_valid),
        .o_data  (rsp_rdata),
        .o_count (w_fifo_count)
    );

`ifdef SRAM_FE_STATS_EN
    logic [31:0] r_stat_rd_cnt;
    logic [31:0] r_stat_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_rd_cnt <= '0;
            r_stat_wr_cnt <= '0;
        end else begin
            if (w_rd_fire) begin
                r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
            end
            if (w_wr_fire) begin
                r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
            end
        end
    end

    assign stat_rd_cnt = r_stat_rd_cnt;
    assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule
